// File: rtl/matrix_result_serializer.sv
// Captures one complete result matrix and streams it out row-major, one element
// per transfer, with row/column tags and an end-of-matrix marker.
module matrix_result_serializer #(
  parameter int C_DATA_WIDTH = 18,
  parameter int ROWS         = 8,
  parameter int COLUMNS      = 5,
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW = (COLUMNS > 1) ? $clog2(COLUMNS) : 1
) (
  input  logic                                  clk_i,
  input  logic                                  reset_i,
  input  logic                                  valid_i,
  output logic                                  ready_o,
  input  logic [ROWS*COLUMNS*C_DATA_WIDTH-1:0]  c_i,
  output logic                                  valid_o,
  input  logic                                  ready_i,
  output logic [C_DATA_WIDTH-1:0]               data_o,
  output logic [RW-1:0]                         row_o,
  output logic [CW-1:0]                         col_o,
  output logic                                  last_o
);

  localparam int N  = ROWS * COLUMNS;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLUMNS - 1);

  // Handshake: an element moves downstream on a rising edge where valid_o && ready_i;
  // a matrix is captured on a rising edge where ready_o && valid_i.

  logic [C_DATA_WIDTH-1:0] buf_q [N];

  logic [0:0]              state_q, state_d;
  logic                    ready_q, ready_d;
  logic                    valid_q, valid_d;
  logic                    last_q,  last_d;
  logic [C_DATA_WIDTH-1:0] data_q,  data_d;
  logic [RW-1:0]           row_q,   row_d;
  logic [CW-1:0]           col_q,   col_d;
  logic [IW-1:0]           idx_q,   idx_d;

  logic [RW-1:0]           row_inc;
  logic [CW-1:0]           col_inc;
  logic [IW-1:0]           idx_inc;

  always_comb begin
    if (col_q == COL_LAST) begin
      col_inc = '0;
      row_inc = row_q + RW'(1);
    end else begin
      col_inc = col_q + CW'(1);
      row_inc = row_q;
    end
    idx_inc = idx_q + IW'(1);
  end

  always_comb begin
    state_d = state_q;
    ready_d = ready_q;
    valid_d = valid_q;
    last_d  = last_q;
    data_d  = data_q;
    row_d   = row_q;
    col_d   = col_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (valid_i) begin
          state_d = S_SEND;
          ready_d = 1'b0;
          valid_d = 1'b1;
          row_d   = '0;
          col_d   = '0;
          idx_d   = '0;
          // Element (0,0) comes straight from c_i so it is on the bus the next cycle.
          data_d  = c_i[0 +: C_DATA_WIDTH];
          last_d  = (N == 1);
        end
      end
      S_SEND: begin
        if (ready_i) begin
          if (last_q) begin
            state_d = S_IDLE;
            ready_d = 1'b1;
            valid_d = 1'b0;
            last_d  = 1'b0;
          end else begin
            row_d  = row_inc;
            col_d  = col_inc;
            idx_d  = idx_inc;
            data_d = buf_q[idx_inc];
            last_d = (row_inc == ROW_LAST) && (col_inc == COL_LAST);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      data_q  <= data_d;
      row_q   <= row_d;
      col_q   <= col_d;
      idx_q   <= idx_d;
    end
  end

  // Snapshot buffer: contents only matter while sending, so it carries no reset.
  always_ff @(posedge clk_i) begin
    if (!reset_i && (state_q == S_IDLE) && valid_i) begin
      for (int i = 0; i < N; i++) begin
        buf_q[i] <= c_i[i*C_DATA_WIDTH +: C_DATA_WIDTH];
      end
    end
  end

  assign ready_o = ready_q;
  assign valid_o = valid_q;
  assign last_o  = last_q;
  assign data_o  = data_q;
  assign row_o   = row_q;
  assign col_o   = col_q;

endmodule

// File: tb/tb_matrix_result_serializer.sv
// Bench for matrix_result_serializer: a frame-level queue model is checked against
// the DUT on every cycle, plus literal checks on frame timing and known elements.
module tb_matrix_result_serializer;

  localparam int W    = 18;
  localparam int ROWS = 8;
  localparam int COLS = 5;
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int N    = ROWS * COLS;
  localparam int EW   = W + RW + CW;

  logic                clk = 1'b0;
  logic                reset_i;
  logic                valid_i;
  logic                ready_o;
  logic [N*W-1:0]      c_i;
  logic                valid_o;
  logic                ready_i;
  logic [W-1:0]        data_o;
  logic [RW-1:0]       row_o;
  logic [CW-1:0]       col_o;
  logic                last_o;

  matrix_result_serializer #(
    .C_DATA_WIDTH(W), .ROWS(ROWS), .COLUMNS(COLS)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .valid_i(valid_i), .ready_o(ready_o),
    .c_i(c_i), .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o),
    .row_o(row_o), .col_o(col_o), .last_o(last_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Expected elements of the frame in flight, packed {data,row,col}.
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] obs_q[$];
  bit m_known = 0;
  bit m_busy = 0;
  bit m_post_reset = 0;

  always @(posedge clk) begin
    if (reset_i) begin
      m_known = 1;
      m_busy = 0;
      m_post_reset = 1;
      exp_q.delete();
    end else if (m_known) begin
      if (!m_busy) begin
        if (valid_i) begin
          for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
              exp_q.push_back({c_i[(r*COLS+c)*W +: W], RW'(r), CW'(c)});
          m_busy = 1;
          m_post_reset = 0;
        end
      end else if (ready_i) begin
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) m_busy = 0;
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (m_known) begin
      check("ready_o", 32'(ready_o), 32'(!m_busy));
      check("valid_o", 32'(valid_o), 32'(m_busy));
      if (m_busy) begin
        check("element", 32'({data_o, row_o, col_o}), 32'(exp_q[0]));
        check("last_o", 32'(last_o), 32'(exp_q.size() == 1));
      end else begin
        check("last_o_idle", 32'(last_o), 32'd0);
        if (m_post_reset) check("reset_outputs", 32'({data_o, row_o, col_o}), 32'd0);
      end
    end
    if (valid_o === 1'b1 && ready_i === 1'b1) obs_q.push_back({data_o, row_o, col_o});
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_ramp();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        c_i[(r*COLS+c)*W +: W] = W'(r*16 + c);
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++) c_i[i*W +: W] = W'($urandom);
  endtask

  task automatic capture();
    valid_i = 1'b1;
    step();
    valid_i = 1'b0;
  endtask

  // Runs until ready_o returns; reports edges taken, or flags a timeout.
  task automatic run_frame(input bit rnd_ready, input bit toggle_valid, output int edges);
    edges = 0;
    while (edges < 500) begin
      if (rnd_ready) ready_i = 1'($urandom_range(0, 1));
      if (toggle_valid) valid_i = ~valid_i;
      step();
      edges++;
      if (ready_o) break;
    end
    valid_i = 1'b0;
    check("frame_timeout", 32'(ready_o), 32'd1);
  endtask

  int e;

  initial begin
    reset_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0; c_i = '0;

    // Reset held two cycles, then idle with ready_i toggling (no effect).
    step(); step();
    reset_i = 1'b0;
    check("rst_ready", 32'(ready_o), 32'd1);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_data", 32'(data_o), 32'd0);
    check("rst_last", 32'(last_o), 32'd0);
    ready_i = 1'b1; step(); ready_i = 1'b0; step();

    // Full frame, ramp data, ready_i tied high.
    fill_ramp();
    obs_q.delete();
    ready_i = 1'b1;
    capture();
    run_frame(0, 0, e);
    check("frame_cycles", 32'(1 + e), 32'd41);
    check("frame_count", 32'(obs_q.size()), 32'd40);
    if (obs_q.size() == 40) begin
      check("elem_0_0", 32'(obs_q[0]), 32'({18'd0, 3'd0, 3'd0}));
      check("elem_1_0", 32'(obs_q[5]), 32'({18'd16, 3'd1, 3'd0}));
      check("elem_3_2", 32'(obs_q[17]), 32'({18'd50, 3'd3, 3'd2}));
      check("elem_7_4", 32'(obs_q[39]), 32'({18'd116, 3'd7, 3'd4}));
    end
    step();

    // Backpressure: ready_i random at 50%.
    for (int k = 0; k < 3; k++) begin
      fill_random();
      obs_q.delete();
      capture();
      run_frame(1, 0, e);
      check("bp_count", 32'(obs_q.size()), 32'd40);
      ready_i = 1'b0;
      repeat ($urandom_range(1, 3)) step();
    end

    // Input changes during SEND must not reach the output or cause recapture.
    fill_random();
    obs_q.delete();
    capture();
    for (int i = 0; i < N; i++) c_i[i*W +: W] = 18'h3FFFF;
    run_frame(1, 1, e);
    check("snap_count", 32'(obs_q.size()), 32'd40);
    step();
    check("snap_no_recapture", 32'(valid_o), 32'd0);

    // Reset after the 12th transfer, then a fresh frame from (0,0).
    fill_random();
    obs_q.delete();
    ready_i = 1'b1;
    capture();
    repeat (12) step();
    check("mid_count", 32'(obs_q.size()), 32'd12);
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    check("mid_valid", 32'(valid_o), 32'd0);
    check("mid_ready", 32'(ready_o), 32'd1);
    step();
    fill_ramp();
    obs_q.delete();
    capture();
    run_frame(0, 0, e);
    check("after_rst_count", 32'(obs_q.size()), 32'd40);
    if (obs_q.size() > 0) check("after_rst_first", 32'(obs_q[0]), 32'd0);

    // Back-to-back: next valid_i raised on the first ready_o cycle.
    fill_random();
    capture();
    run_frame(0, 0, e);
    fill_random();
    obs_q.delete();
    capture();
    check("b2b_ready", 32'(ready_o), 32'd0);
    check("b2b_valid", 32'(valid_o), 32'd1);
    check("b2b_first", 32'({data_o, row_o, col_o}), 32'({c_i[0 +: W], 3'd0, 3'd0}));
    run_frame(0, 0, e);
    check("b2b_count", 32'(obs_q.size()), 32'd40);
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/matrix_result_serializer.md
Name: matrix_result_serializer

Overview:
- Consumer-side partner of the matrix multiplier.
- Captures one complete result matrix C when the multiplier flags it valid.
- Streams C out element by element in row-major order over a valid/ready interface, with row/column tags and an end-of-matrix marker.
- Sits between the multiplier's c_o/valid_o outputs and a narrow downstream sink (FIFO, bus writer, checker).

Parameters:
- C_DATA_WIDTH, 18, width of one C element (2*8 + $clog2(4)).
- ROWS, 8, rows of C (A_ROWS).
- COLUMNS, 5, columns of C (B_COLUMNS).
- Derived: RW = max(1, $clog2(ROWS)), CW = max(1, $clog2(COLUMNS)).

Ports:
- clk_i  input  1  single clock; all logic on rising edge.
- reset_i  input  1  synchronous, active-high reset.
- valid_i  input  1  c_i holds a complete valid matrix.
- ready_o  output  1  block can capture a matrix this cycle.
- c_i  input  ROWS*COLUMNS*C_DATA_WIDTH  flattened C; element (r,c) at bits [(r*COLUMNS+c)*C_DATA_WIDTH +: C_DATA_WIDTH].
- valid_o  output  1  data_o/row_o/col_o/last_o are valid.
- ready_i  input  1  downstream accepts the current element.
- data_o  output  C_DATA_WIDTH  current element value.
- row_o  output  RW  row index of the current element.
- col_o  output  CW  column index of the current element.
- last_o  output  1  current element is (ROWS-1, COLUMNS-1).

Behaviour:
- Reset (synchronous, reset_i high at a rising edge):
  - State goes to IDLE.
  - ready_o=1, valid_o=0, last_o=0, data_o=0, row_o=0, col_o=0.
  - Captured buffer contents are don't-care.
- States: IDLE, SEND. All outputs are registered.
- IDLE:
  - ready_o=1, valid_o=0.
  - On valid_i=1, copy c_i into the internal buffer, clear the row/col counters, and enter SEND.
  - Next cycle: ready_o=0, valid_o=1, data_o = element (0,0), row_o=0, col_o=0.
  - Capture-to-first-valid latency is 1 cycle.
- SEND:
  - ready_o=0. valid_i is ignored; upstream must hold its matrix until ready_o returns.
  - Transfer occurs when valid_o && ready_i.
  - While valid_o=1 and ready_i=0, data_o, row_o, col_o and last_o hold stable.
  - On transfer of a non-last element:
    - If col < COLUMNS-1, col increments.
    - Otherwise col wraps to 0 and row increments.
    - Next element is presented the following cycle, giving 1 element/cycle throughput under continuous ready_i.
  - last_o=1 exactly when row_o=ROWS-1 and col_o=COLUMNS-1.
  - On transfer of the last element: go to IDLE; next cycle valid_o=0, last_o=0, ready_o=1.
- No capture/send overlap: at least 1 idle cycle separates the last transfer from the next capture.
- Frame timing:
  - Exactly ROWS*COLUMNS transfers per frame.
  - With ready_i held at 1, a frame occupies 1 + ROWS*COLUMNS cycles from capture to ready_o re-asserting.
- ready_i=1 while valid_o=0 has no effect.
- Captured data is snapshotted; changes on c_i during SEND do not affect output.
- Reset mid-frame:
  - Remaining elements are dropped.
  - valid_o=0 and ready_o=1 from the cycle after reset; no partial resume.
- Reset and valid_i in the same cycle: reset wins, nothing is captured.
- Degenerate ROWS=COLUMNS=1: one element, presented with last_o=1; row_o and col_o are 1 bit, always 0.

Test Plan:
- Reset, then idle: after reset_i high for 2 cycles → ready_o=1, valid_o=0, data_o=0, last_o=0.
- Full frame, ready_i tied 1, C(r,c) = r*16+c, valid_i pulsed 1 cycle:
  - 40 consecutive transfers in order (0,0),(0,1)…(0,4),(1,0)…(7,4).
  - data_o matches C(r,c) each cycle; last_o only on (7,4).
  - ready_o=1 on cycle 41 after capture.
- Backpressure: ready_i random at 50%:
  - While ready_i=0, outputs are unchanged.
  - Same 40-element sequence with no loss or duplication.
- Input changes during SEND: after capture, drive c_i all 0x3FFFF and toggle valid_i → streamed values are still the captured matrix, with no second capture.
- Reset mid-frame: assert reset_i after the 12th transfer → next cycle valid_o=0, ready_o=1; a new matrix then streams from (0,0).
- Back-to-back frames: second valid_i held from the cycle after the first last transfer → captured on the first ready_o=1 cycle; second frame streams correctly.
